// File: rtl/intc_priority_arbiter.sv
// Priority arbiter behind the interrupt mode-select stage: picks the highest pending line,
// compares it against the CPU mask, and runs the request/ack/clear handshake.
module intc_priority_arbiter #(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned PRIO_W    = 4,
    localparam int unsigned ID_W     = $clog2(NUM_LINES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_LINES-1:0]        priority_selected,
    input  logic [NUM_LINES*PRIO_W-1:0] line_prio,
    input  logic [PRIO_W-1:0]           mask_level,
    output logic                        irq_req,
    output logic [ID_W-1:0]             irq_id,
    output logic [PRIO_W-1:0]           irq_level,
    input  logic                        irq_ack,
    output logic [NUM_LINES-1:0]        clr_pend
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StClear
    } state_e;

    state_e                 state_q;
    logic                   irq_req_q;
    logic [ID_W-1:0]        irq_id_q;
    logic [PRIO_W-1:0]      irq_level_q;
    logic [NUM_LINES-1:0]   clr_pend_q;

    logic                   cand_valid_d, cand_valid_q;
    logic [ID_W-1:0]        cand_id_d, cand_id_q;
    logic [PRIO_W-1:0]      cand_level_d, cand_level_q;
    logic [NUM_LINES-1:0]   served_onehot;

    // Strict '>' keeps the lowest index on ties and never selects a level-0 line.
    always_comb begin
        cand_level_d = '0;
        cand_id_d    = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (priority_selected[i] && (line_prio[i*PRIO_W +: PRIO_W] > cand_level_d)) begin
                cand_level_d = line_prio[i*PRIO_W +: PRIO_W];
                cand_id_d    = ID_W'(i);
            end
        end
        cand_valid_d = (cand_level_d != '0) && (cand_level_d > mask_level);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_valid_q <= 1'b0;
            cand_id_q    <= '0;
            cand_level_q <= '0;
        end else begin
            cand_valid_q <= cand_valid_d;
            cand_id_q    <= cand_id_d;
            cand_level_q <= cand_level_d;
        end
    end

    always_comb begin
        served_onehot           = '0;
        served_onehot[irq_id_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            irq_req_q   <= 1'b0;
            irq_id_q    <= '0;
            irq_level_q <= '0;
            clr_pend_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    clr_pend_q <= '0;
                    if (cand_valid_q) begin
                        state_q     <= StReq;
                        irq_req_q   <= 1'b1;
                        irq_id_q    <= cand_id_q;
                        irq_level_q <= cand_level_q;
                    end
                end
                StReq: begin
                    if (irq_ack) begin
                        // id/level stay frozen on the served line through StClear.
                        state_q    <= StClear;
                        irq_req_q  <= 1'b0;
                        clr_pend_q <= served_onehot;
                    end else if (!cand_valid_q) begin
                        state_q   <= StIdle;
                        irq_req_q <= 1'b0;
                    end else if (cand_level_q > irq_level_q) begin
                        irq_id_q    <= cand_id_q;
                        irq_level_q <= cand_level_q;
                    end
                end
                StClear: begin
                    state_q    <= StIdle;
                    irq_req_q  <= 1'b0;
                    clr_pend_q <= '0;
                end
                default: begin
                    state_q    <= StIdle;
                    irq_req_q  <= 1'b0;
                    clr_pend_q <= '0;
                end
            endcase
        end
    end

    assign irq_req   = irq_req_q;
    assign irq_id    = irq_id_q;
    assign irq_level = irq_level_q;
    assign clr_pend  = clr_pend_q;

endmodule

// File: doc/intc_priority_arbiter.md
Name: intc_priority_arbiter

Overview:
- Downstream stage of the interrupt-controller mode-select block. It consumes the per-line `priority_selected` vector that stage already gated by the I bit / INTM1 / IPR_EN.
- Resolves the highest-priority pending line and compares it against the CPU mask level.
- Drives a held request with line ID and level to the CPU core, then completes an ack handshake that clears the served source.

Parameters:
- NUM_LINES, 8, number of request lines; matches LINE_WIDTH_FULL of the mode-select stage.
- PRIO_W, 4, width of each line's priority level; level 0 means never accepted.
- ID_W, $clog2(NUM_LINES), derived width of the line ID; not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- priority_selected  input  NUM_LINES  gated pending lines from mode-select; bit i = line i.
- line_prio  input  NUM_LINES*PRIO_W  packed levels; line i at [i*PRIO_W +: PRIO_W].
- mask_level  input  PRIO_W  CPU interrupt mask; a line is accepted only if its level > mask_level.
- irq_req  output  1  request to CPU.
- irq_id  output  ID_W  ID of the requested line.
- irq_level  output  PRIO_W  level of the requested line.
- irq_ack  input  1  CPU accept; one-cycle pulse.
- clr_pend  output  NUM_LINES  one-hot, one-cycle pulse that clears the served source's pending flag.

Behaviour:
- Reset (rst high at a clock edge): irq_req=0, irq_id=0, irq_level=0, clr_pend=0, candidate register cleared, FSM=IDLE. Reset takes effect mid-handshake as well; any request in flight is dropped and no clr_pend pulse is issued.
- Stage 1 (combinational resolve):
  - Candidate = the set bit of priority_selected with the largest line_prio.
  - Ties go to the lowest index.
  - Lines with level 0 are ignored.
  - cand_valid = some line qualifies AND its level > mask_level (unsigned compare).
- Stage 2 (candidate register): cand_valid, cand_id and cand_level are registered every cycle.
- FSM states: IDLE, REQ, CLEAR; the FSM uses only registered candidate values.
- IDLE:
  - If cand_valid_q, go to REQ; irq_req<=1, irq_id<=cand_id_q, irq_level<=cand_level_q.
  - Latency: priority_selected rises before edge N, candidate is registered at edge N, irq_req is high after edge N+1 (2 cycles).
- REQ, priority order when several conditions hold in the same cycle:
  1. irq_ack=1 wins over any simultaneous candidate change.
     - clr_pend<=one-hot(irq_id) for exactly 1 cycle, irq_req<=0, go to CLEAR.
     - irq_id and irq_level hold their served values through CLEAR.
  2. Else if !cand_valid_q (line withdrawn or mask raised): irq_req<=0, go to IDLE, no clr_pend.
  3. Else if cand_level_q > irq_level (preemption before ack): update irq_id/irq_level in place; irq_req stays 1.
  4. Otherwise hold; irq_id and irq_level are stable while irq_req=1 except under rule 3.
- CLEAR:
  - One-cycle dead state so source clearing propagates through mode-select.
  - irq_req=0, clr_pend=0 after its pulse; unconditionally go to IDLE.
  - A still-pending line may re-request from IDLE after normal latency, giving at least 2 idle cycles between requests.
- irq_ack outside REQ is ignored: no state change, no clr_pend.
- Equal-level change while in REQ causes no switch, even if a lower index appears.
- mask_level is sampled only via the registered candidate; a mask change takes effect 1 cycle later.
- clr_pend is never multi-hot; it is 0 in every cycle except the one following the ack edge.

Test Plan (NUM_LINES=8, PRIO_W=4):
- Reset + single request: rst 2 cycles, then priority_selected=8'h04, line_prio[2]=5, mask=0.
  - Expect irq_req high 2 cycles later with irq_id=2, irq_level=5.
  - Ack at cycle k: clr_pend=8'h04 in cycle k+1, irq_req=0.
- Priority and tie: priority_selected=8'h16 with levels line1=7, line2=9, line4=9.
  - Expect irq_id=2, irq_level=9 (tie resolved to lowest index).
- Mask and withdraw:
  - Line3 level 4, mask=4: irq_req never asserts.
  - Mask=3: request with id=3. Then mask=6 before ack: irq_req drops within 2 cycles, clr_pend stays 0.
- Preemption and ack collision:
  - In REQ on line0 level 3, raise line6 level 12: irq_id updates to 6 and irq_req stays high.
  - Repeat, with line6 appearing in the same cycle as irq_ack for line0: clr_pend=8'h01 and irq_id stays 0 through CLEAR.
- Spurious ack and reset mid-request:
  - irq_ack pulses in IDLE: no outputs change.
  - rst asserted while in REQ: next cycle all outputs 0, no clr_pend pulse.
- Back-to-back: line5 held pending (level 2) and acked each time.
  - Expect at least 2 idle cycles between consecutive irq_req assertions.
  - Exactly one clr_pend=8'h20 pulse per ack.
